// File: rtl/pov_msg_buffer.sv
// Ping-pong message store for the POV display path.
// One bank takes one-cycle edit commands from the text-entry control while the other bank
// is shown to the column scanner. A commit swaps the banks.
module pov_msg_buffer #(
   parameter int unsigned    DEPTH      = 16,
   parameter int unsigned    CW         = 8,
   parameter logic [CW-1:0]  ENHE_CODE  = 8'hF1,
   parameter logic [CW-1:0]  COMMA_CODE = 8'h2C,
   parameter logic [CW-1:0]  BLANK_CODE = 8'h20,
   parameter int unsigned    AW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] char_in,
   input  logic          load,
   input  logic          add,
   input  logic          delete,
   input  logic          add_enhe,
   input  logic          change_virgul,
   input  logic          complete,
   input  logic          change,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          upd,
   input  logic [AW-1:0] rd_addr,
   output logic [CW-1:0] rd_data,
   output logic [AW:0]   msg_len,
   output logic          msg_valid
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [CW-1:0] mem [2][DEPTH];
   logic          disp_sel;
   logic          edit_sel;
   logic [AW:0]   count_d;
   logic          overflow_d;
   logic          upd_d;
   logic          wr_en;
   logic [CW-1:0] wr_code;
   logic          rd_hit;

   // The activity strobe carries no state; upd is driven only by accepted edits.
   logic unused_change;
   assign unused_change = change;

   assign edit_sel = ~disp_sel;
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign rd_hit   = msg_valid && ({1'b0, rd_addr} < msg_len);

   // Decode this edge's edit command: load > delete > add.
   always_comb begin
      count_d    = count;
      overflow_d = overflow;
      upd_d      = 1'b0;
      wr_en      = 1'b0;
      wr_code    = add_enhe      ? ENHE_CODE  :
                   change_virgul ? COMMA_CODE : char_in;
      if (load) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (delete) begin
         if (!empty) begin
            count_d = count - 1'b1;
            upd_d   = 1'b1;
         end
      end else if (add) begin
         if (!full) begin
            wr_en   = 1'b1;
            count_d = count + 1'b1;
            upd_d   = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Edit bank write; data storage needs no reset, it is never read before a commit.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem[edit_sel][count[AW-1:0]] <= wr_code;
      end
   end

   // Control registers, commit swap and registered display read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         overflow  <= 1'b0;
         upd       <= 1'b0;
         disp_sel  <= 1'b0;
         msg_len   <= '0;
         msg_valid <= 1'b0;
         rd_data   <= BLANK_CODE;
      end else begin
         count    <= count_d;
         overflow <= overflow_d;
         upd      <= upd_d;
         // Read uses the bank selected before this edge, so a commit shows up one edge later.
         rd_data  <= rd_hit ? mem[disp_sel][rd_addr] : BLANK_CODE;
         if (complete) begin
            // Length includes an add accepted on this same edge.
            msg_len   <= count_d;
            disp_sel  <= ~disp_sel;
            msg_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pov_msg_buffer.sv
// Scoreboard bench for pov_msg_buffer: a queue-based message model predicts every
// post-edge output, a separate monitor compares one edge later.
module tb_pov_msg_buffer;

   localparam int DEPTH = 16;
   localparam int CW    = 8;
   localparam int AW    = 4;
   localparam logic [7:0] ENHE  = 8'hF1;
   localparam logic [7:0] COMMA = 8'h2C;
   localparam logic [7:0] BLANK = 8'h20;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] char_in = '0;
   logic          load = 1'b0, add = 1'b0, delete = 1'b0;
   logic          add_enhe = 1'b0, change_virgul = 1'b0, complete = 1'b0, change = 1'b0;
   logic          full, empty, overflow, upd, msg_valid;
   logic [AW:0]   count, msg_len;
   logic [AW-1:0] rd_addr = '0;
   logic [CW-1:0] rd_data;

   pov_msg_buffer #(
      .DEPTH(DEPTH), .CW(CW), .ENHE_CODE(ENHE), .COMMA_CODE(COMMA), .BLANK_CODE(BLANK)
   ) dut (
      .clk(clk), .reset(reset), .char_in(char_in), .load(load), .add(add), .delete(delete),
      .add_enhe(add_enhe), .change_virgul(change_virgul), .complete(complete),
      .change(change), .full(full), .empty(empty), .count(count), .overflow(overflow),
      .upd(upd), .rd_addr(rd_addr), .rd_data(rd_data), .msg_len(msg_len),
      .msg_valid(msg_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cnt;
      bit   full;
      bit   empty;
      bit   ovf;
      bit   upd;
      logic [7:0] rd;
      int   mlen;
      bit   mv;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: the message as plain queues of characters.
   logic [7:0] ebuf[$];
   logic [7:0] dmsg[$];
   bit         m_mv  = 1'b0;
   bit         m_ovf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Monitor: one expectation per issued command, checked just after the sampling edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("full", 32'(full), 32'(e.full));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("upd", 32'(upd), 32'(e.upd));
            chk("rd_data", 32'(rd_data), 32'(e.rd));
            chk("msg_len", 32'(msg_len), 32'(e.mlen));
            chk("msg_valid", 32'(msg_valid), 32'(e.mv));
         end
      end
   end

   // Drive one command on the negedge and push the model's prediction for the next edge.
   task automatic step(input bit rst, input bit ld, input bit del, input bit ad,
                       input bit enh, input bit vir, input bit cmp,
                       input logic [7:0] ch, input logic [3:0] addr);
      exp_t e;
      logic [7:0] code;
      @(negedge clk);
      reset = rst; load = ld; delete = del; add = ad; add_enhe = enh;
      change_virgul = vir; complete = cmp; char_in = ch; rd_addr = addr;
      change = 1'($urandom_range(0, 1));
      e.upd = 1'b0;
      e.rd  = (m_mv && int'(addr) < dmsg.size()) ? dmsg[addr] : BLANK;
      if (rst) begin
         ebuf.delete();
         dmsg.delete();
         m_mv  = 1'b0;
         m_ovf = 1'b0;
         e.rd  = BLANK;
      end else begin
         code = enh ? ENHE : (vir ? COMMA : ch);
         if (ld) begin
            ebuf.delete();
            m_ovf = 1'b0;
         end else if (del) begin
            if (ebuf.size() > 0) begin
               void'(ebuf.pop_back());
               e.upd = 1'b1;
            end
         end else if (ad) begin
            if (ebuf.size() < DEPTH) begin
               ebuf.push_back(code);
               e.upd = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (cmp) begin
            dmsg = ebuf;
            m_mv = 1'b1;
         end
      end
      e.cnt   = ebuf.size();
      e.full  = (ebuf.size() == DEPTH);
      e.empty = (ebuf.size() == 0);
      e.ovf   = m_ovf;
      e.mlen  = dmsg.size();
      e.mv    = m_mv;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [3:0] addr);
      step(0, 0, 0, 0, 0, 0, 0, 8'h00, addr);
   endtask

   task automatic put(input logic [7:0] ch);
      step(0, 0, 0, 1, 0, 0, 0, ch, 4'd0);
   endtask

   initial begin
      bit after_cmp;
      // Reset, "HI", commit, read back including a blank past the end.
      step(1, 0, 0, 0, 0, 0, 0, 8'h00, 4'd0);
      idle(4'd0);
      put(8'h48);
      put(8'h49);
      step(0, 0, 0, 0, 0, 0, 1, 8'h00, 4'd0);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd0);
      idle(4'd1);
      idle(4'd2);
      // n-tilde entry: add N, delete, add with add_enhe, commit.
      put(8'h4E);
      step(0, 0, 1, 0, 0, 0, 0, 8'h00, 4'd0);
      step(0, 0, 0, 1, 1, 0, 0, 8'h4E, 4'd0);
      step(0, 0, 0, 0, 0, 0, 1, 8'h00, 4'd0);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd0);
      idle(4'd1);
      // Comma substitution, and add_enhe winning over change_virgul.
      step(0, 0, 0, 1, 0, 1, 0, 8'h41, 4'd0);
      step(0, 0, 0, 1, 1, 1, 1, 8'h41, 4'd0);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd0);
      idle(4'd1);
      // Seventeen adds: last one dropped, then load clears.
      for (int i = 0; i < 17; i++) put(8'h61 + 8'(i));
      idle(4'd0);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd0);
      // Delete on empty, then add+complete at count 3 with reads around the swap.
      step(0, 0, 1, 0, 0, 0, 0, 8'h00, 4'd0);
      put(8'h31);
      put(8'h32);
      put(8'h33);
      step(0, 0, 0, 1, 0, 0, 1, 8'h34, 4'd0);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00, 4'd3);
      idle(4'd4);
      // Reset mid-message while a message is displayed.
      put(8'h58);
      step(1, 0, 0, 1, 0, 0, 1, 8'h59, 4'd0);
      idle(4'd0);

      // Random traffic; control always follows a commit with a load.
      after_cmp = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         int  r;
         bit  rst, ld, cmp;
         r   = int'($urandom_range(0, 199));
         rst = (r == 0);
         ld  = after_cmp || (r < 10);
         cmp = ($urandom_range(0, 11) == 0);
         step(rst, ld, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), cmp,
              8'($urandom), 4'($urandom));
         after_cmp = cmp && !rst;
      end

      idle(4'd0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pov_msg_buffer.md
# pov_msg_buffer

Message storage stage directly downstream of the text-entry control FSM in the POV display path. It executes that FSM's one-cycle edit commands (add, delete, ñ substitution, comma insertion, load, complete) on an edit buffer, feeds the buffer-full flag back to the FSM, and on commit hands a frozen copy of the message to the POV column scanner through a registered read port. Storage is ping-pong: one bank is edited while the other is displayed.

## Interface
- DEPTH, 16, message capacity in characters (power of two, ≥2)
- CW, 8, character code width
- ENHE_CODE, 8'hF1, code written for ñ
- COMMA_CODE, 8'h2C, code written for comma
- BLANK_CODE, 8'h20, code returned for addresses beyond the message
- AW, $clog2(DEPTH), address width (derived)

- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- char_in  in  CW  character code from the keyboard decoder, stable while add is high
- load  in  1  clear edit buffer
- add  in  1  append one character
- delete  in  1  remove last character
- add_enhe  in  1  with add: write ENHE_CODE instead of char_in
- change_virgul  in  1  with add: write COMMA_CODE instead of char_in
- complete  in  1  commit edit buffer to display
- change  in  1  edit-activity strobe from control
- full  out  1  count == DEPTH; drives control's counter-full input
- empty  out  1  count == 0
- count  out  AW+1  characters in edit buffer
- overflow  out  1  sticky: an add was dropped because full
- upd  out  1  one-cycle pulse after an accepted edit
- rd_addr  in  AW  display scanner read address
- rd_data  out  CW  registered display character
- msg_len  out  AW+1  committed message length
- msg_valid  out  1  a message has been committed since reset

## Operation
- Registers: two banks mem[2][DEPTH], disp_sel (bank shown), count, msg_len, msg_valid, overflow, upd, rd_data. Edit bank = !disp_sel.
- Commands are sampled once per posedge; control holds each for exactly one clock.
- Priority per edge: reset > load > delete > add. complete is evaluated after add in the same edge.
- load: count←0, overflow←0. Display bank, msg_len, msg_valid untouched.
- delete: count>0 → count−1, upd←1; count==0 → no-op, no upd.
- add: code = ENHE_CODE if add_enhe, else COMMA_CODE if change_virgul, else char_in (add_enhe wins if both). count<DEPTH → edit[count]←code, count+1, upd←1; count==DEPTH → dropped, overflow←1.
- ñ entry arrives as delete (one cycle) then add+add_enhe (next cycle): net effect replaces last char with ñ.
- complete: msg_len←count after this edge's add (count+1 if add accepted), disp_sel←!disp_sel, msg_valid←1. count is not cleared (control follows with load).
- complete with count resulting 0: commit still occurs, msg_len=0.
- change: no state effect; upd is driven only by accepted edits.
- Read: rd_data←(rd_addr < msg_len) ? disp[rd_addr] : BLANK_CODE; msg_valid=0 → BLANK_CODE.
- full/empty are combinational from count.

## Timing
- Reset values: count=0, full=0, empty=1, overflow=0, upd=0, disp_sel=0, msg_len=0, msg_valid=0, rd_data=BLANK_CODE; memory contents undefined, never read before first commit.
- Control outputs change on negedge; this block samples on the following posedge (half-cycle setup).
- Edit latency: count/full/empty reflect a command immediately after the sampling edge; full reaches control before its next negedge decision.
- upd high for exactly the cycle after an accepted edit.
- Read latency 1 cycle: rd_addr at edge N → rd_data valid after edge N.
- Commit: disp_sel/msg_len switch at the complete edge; reads sampled at that same edge still use the old bank; next edge reads the new bank.
- Reset mid-operation: all registers to reset values at the edge reset is high; commands in that cycle ignored.

## Test plan
- Reset, add 'H'(48),'I'(49), complete → msg_len=2, msg_valid=1; rd_addr 0,1,2 → 8'h48, 8'h49, 8'h20 one cycle later.
- Add 'N'(4E), delete, add+add_enhe → count=1, committed rd_data[0]=8'hF1; upd pulses three times.
- Add+change_virgul with char_in=8'h41 → stored 8'h2C.
- Add 17 chars with DEPTH=16 → full=1 after 16th, 17th dropped, overflow=1, count=16; load → count=0, overflow=0, empty=1.
- Delete on empty → count stays 0, no upd; add+complete same cycle with count=3 → msg_len=4, old bank readable until that edge, new bank after.
- Reset asserted mid-message with msg_valid=1 → msg_valid=0, rd_data=8'h20, count=0 next cycle.
